// File: rtl/program_loader_if.sv
// Byte-stream and system-bus signal bundle for the program loader.
//
// Stream side : in_data / in_valid from the feeder, in_ready back to it.
// Bus side    : bus_out / bus_oe drive the shared 8-bit system bus.
//               MI strobes the RAM address register and WE strobes the RAM write.
//
// Modports:
//   master - the loader itself (consumes the stream, drives the bus)
//   slave  - the environment (feeder plus RAM/address register)
interface program_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic       MI;
  logic       WE;

  modport master (
    input  in_data,
    input  in_valid,
    output in_ready,
    output bus_out,
    output bus_oe,
    output MI,
    output WE
  );

  modport slave (
    output in_data,
    output in_valid,
    input  in_ready,
    input  bus_out,
    input  bus_oe,
    input  MI,
    input  WE
  );
endinterface

// File: rtl/program_loader.sv
// Program loader: writes a DEPTH-byte stream into RAM locations 0..DEPTH-1
// over the shared 8-bit bus and holds the CPU halted while doing so.
//
// Each byte takes an ADDR cycle (address onto the bus with MI), a WAIT cycle
// (or more) for the stream handshake, and a WRITE cycle (data onto the bus
// with WE). A sticky done flag is raised after the last byte is written.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   start     begin a session (honoured in IDLE or DONE only)
//   abort     end the session and return to IDLE (honoured in any state)
//   lif       stream + bus bundle (master modport)
//   busy      session in progress
//   cpu_halt  CPU stall request, identical to busy
//   done      sticky completion flag
//
// Outputs are registered from the next-state decode, so they carry exactly
// the Moore values of the current state while being glitch-free flops, and
// the asynchronous reset clears them the moment rst rises.
module program_loader #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  program_loader_if.master lif,
  output logic             busy,
  output logic             cpu_halt,
  output logic             done
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_r;
  state_t            state_next_s;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] addr_next_s;
  logic [7:0]        data_r;
  logic [7:0]        data_next_s;
  logic [7:0]        addr_pad_s;

  logic              in_ready_s;
  logic [7:0]        bus_out_s;
  logic              bus_oe_s;
  logic              mi_s;
  logic              we_s;
  logic              busy_s;
  logic              done_s;

  logic              in_ready_r;
  logic [7:0]        bus_out_r;
  logic              bus_oe_r;
  logic              mi_r;
  logic              we_r;
  logic              busy_r;
  logic              done_r;

  // Next-state, address counter and data capture; abort overrides everything.
  always_comb begin
    state_next_s = state_r;
    addr_next_s  = addr_r;
    data_next_s  = data_r;
    case (state_r)
      ST_IDLE: begin
        if (abort) begin
          state_next_s = ST_IDLE;
        end else if (start) begin
          state_next_s = ST_ADDR;
          addr_next_s  = {ADDR_W{1'b0}};
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (abort) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // in_ready is high throughout WAIT, so in_valid alone completes the handshake.
        if (abort) begin
          state_next_s = ST_IDLE;
        end else if (lif.in_valid) begin
          state_next_s = ST_WRITE;
          data_next_s  = lif.in_data;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_WRITE: begin
        if (abort) begin
          state_next_s = ST_IDLE;
        end else if (addr_r == LAST_ADDR) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_ADDR;
          addr_next_s  = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
      ST_DONE: begin
        if (abort) begin
          state_next_s = ST_IDLE;
        end else if (start) begin
          state_next_s = ST_ADDR;
          addr_next_s  = {ADDR_W{1'b0}};
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        addr_next_s  = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Zero-extend the address to the bus width.
  always_comb begin
    addr_pad_s                = 8'h00;
    addr_pad_s[ADDR_W-1:0]    = addr_next_s;
  end

  // Moore output decode of the state being entered on the next edge.
  always_comb begin
    in_ready_s = 1'b0;
    bus_out_s  = 8'h00;
    bus_oe_s   = 1'b0;
    mi_s       = 1'b0;
    we_s       = 1'b0;
    busy_s     = 1'b0;
    done_s     = 1'b0;
    case (state_next_s)
      ST_IDLE: begin
        busy_s = 1'b0;
      end
      ST_ADDR: begin
        bus_oe_s  = 1'b1;
        mi_s      = 1'b1;
        bus_out_s = addr_pad_s;
        busy_s    = 1'b1;
      end
      ST_WAIT: begin
        in_ready_s = 1'b1;
        busy_s     = 1'b1;
      end
      ST_WRITE: begin
        bus_oe_s  = 1'b1;
        we_s      = 1'b1;
        bus_out_s = data_next_s;
        busy_s    = 1'b1;
      end
      ST_DONE: begin
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // State, address counter and data register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      addr_r  <= {ADDR_W{1'b0}};
      data_r  <= 8'h00;
    end else begin
      state_r <= state_next_s;
      addr_r  <= addr_next_s;
      data_r  <= data_next_s;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_r <= 1'b0;
      bus_out_r  <= 8'h00;
      bus_oe_r   <= 1'b0;
      mi_r       <= 1'b0;
      we_r       <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      in_ready_r <= in_ready_s;
      bus_out_r  <= bus_out_s;
      bus_oe_r   <= bus_oe_s;
      mi_r       <= mi_s;
      we_r       <= we_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
    end
  end

  assign lif.in_ready = in_ready_r;
  assign lif.bus_out  = bus_out_r;
  assign lif.bus_oe   = bus_oe_r;
  assign lif.MI       = mi_r;
  assign lif.WE       = we_r;
  assign busy         = busy_r;
  assign cpu_halt     = busy_r;
  assign done         = done_r;

endmodule
